// File: rtl/shared_arb_pkg.sv
// shared_arb_pkg: state encoding, default parameters and helpers shared by
// round_robin_target_arbiter and its priority picker.
package shared_arb_pkg;

   localparam int DEF_NREQ           = 4;
   localparam int DEF_N              = 32;
   localparam int DEF_M              = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1023;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      CAPTURE,
      FINISH
   } arb_state_t;

   // Index width for a requester count; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin search starting one past
// last_grant and wrapping, returning the first pending requester.
module rr_priority_picker
   import shared_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int GW   = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] request,
   input  logic [GW-1:0]   last_grant,
   output logic            found,
   output logic [GW-1:0]   winner
);

   int idx;

   // Walk offsets from farthest to nearest so the nearest pending one wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(last_grant) + k) % NREQ;
         if (request[idx[GW-1:0]]) begin
            found  = 1'b1;
            winner = GW'(idx);
         end
      end
   end

endmodule

// File: rtl/round_robin_target_arbiter.sv
// round_robin_target_arbiter: shares one start/finished target among NREQ
// requesters in round-robin order. Optional WAIT timeout: SHARED_ARB_TIMEOUT_EN.
module round_robin_target_arbiter
   import shared_arb_pkg::*;
#(
   parameter int NREQ           = DEF_NREQ,
   parameter int N              = DEF_N,
   parameter int M              = DEF_M,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   localparam int GW            = idx_width(NREQ)
) (
   input  logic              sm_clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   start_request,
   output logic [NREQ-1:0]   reset_start_request,
   output logic [NREQ-1:0]   finish,
   input  logic [NREQ*N-1:0] input_arguments,
   output logic [NREQ*M-1:0] received_data,
   output logic [N-1:0]      target_arguments,
   output logic              start_target,
   input  logic              target_finished,
   input  logic [M-1:0]      target_data,
   output logic [GW-1:0]     grant_id,
   output logic              busy,
   output logic              timeout_err
);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("round_robin_target_arbiter: unsupported parameter value");
   end

   arb_state_t    state;
   arb_state_t    state_nx;
   logic [GW-1:0] last_grant;
   logic [GW-1:0] winner;
   logic          found;
   logic          wait_expired;
   logic [M-1:0]  slot [NREQ];
   logic [N-1:0]  args [NREQ];

   rr_priority_picker #(
      .NREQ (NREQ),
      .GW   (GW)
   ) u_picker (
      .request    (start_request),
      .last_grant (last_grant),
      .found      (found),
      .winner     (winner)
   );

   for (genvar i = 0; i < NREQ; i++) begin : g_slot
      assign args[i]                 = input_arguments[i*N +: N];
      assign received_data[i*M +: M] = slot[i];
   end

   assign target_arguments = args[grant_id];

   always_ff @(posedge sm_clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // last_grant starts at NREQ-1 so requester 0 is first after reset.
   always_ff @(posedge sm_clk or negedge reset) begin
      if (!reset) begin
         grant_id   <= '0;
         last_grant <= GW'(NREQ - 1);
      end else begin
         if (state == IDLE && found) begin
            grant_id <= winner;
         end
         if (state == FINISH) begin
            last_grant <= grant_id;
         end
      end
   end

   always_ff @(posedge sm_clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREQ; i++) begin
            slot[i] <= '0;
         end
      end else if (state == CAPTURE) begin
         slot[grant_id] <= target_data;
      end
   end

   always_comb begin
      state_nx            = state;
      start_target        = 1'b0;
      reset_start_request = '0;
      finish              = '0;
      busy                = 1'b1;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (found) begin
               state_nx = START;
            end
         end
         START: begin
            start_target                  = 1'b1;
            reset_start_request[grant_id] = 1'b1;
            state_nx                      = WAIT;
         end
         WAIT: begin
            if (target_finished) begin
               state_nx = CAPTURE;
            end else if (wait_expired) begin
               state_nx = FINISH;
            end
         end
         CAPTURE: begin
            state_nx = FINISH;
         end
         FINISH: begin
            finish[grant_id] = 1'b1;
            state_nx         = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

`ifdef SHARED_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] wait_cnt;
   logic          timed_out;

   // Counter holds the number of WAIT cycles already spent.
   always_ff @(posedge sm_clk or negedge reset) begin
      if (!reset) begin
         wait_cnt  <= '0;
         timed_out <= 1'b0;
      end else begin
         if (state == START) begin
            wait_cnt <= '0;
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (state == IDLE) begin
            timed_out <= 1'b0;
         end else if (state == WAIT && !target_finished && wait_expired) begin
            timed_out <= 1'b1;
         end
      end
   end

   assign wait_expired = (state == WAIT) &&
                         (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign timeout_err  = (state == FINISH) && timed_out;
`else
   assign wait_expired = 1'b0;
   assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_round_robin_target_arbiter.sv
// Bench for round_robin_target_arbiter: directed scenarios plus random
// traffic checked cycle by cycle against a round-robin reference model.
module tb_round_robin_target_arbiter;

   localparam int NREQ = 4;
   localparam int N    = 32;
   localparam int M    = 8;
`ifdef SHARED_ARB_TIMEOUT_EN
   localparam int TOC  = 8;
`else
   localparam int TOC  = 1023;
`endif

   logic           sm_clk;
   logic           reset;
   logic [3:0]     start_request;
   logic [3:0]     reset_start_request;
   logic [3:0]     finish;
   logic [127:0]   input_arguments;
   logic [31:0]    received_data;
   logic [31:0]    target_arguments;
   logic           start_target;
   logic           target_finished;
   logic [7:0]     target_data;
   logic [1:0]     grant_id;
   logic           busy;
   logic           timeout_err;

   int             n_cmp;
   int             n_bad;
   int             last_grant;
   logic [7:0]     exp_slot [4];

   round_robin_target_arbiter #(
      .NREQ           (NREQ),
      .N              (N),
      .M              (M),
      .TIMEOUT_CYCLES (TOC)
   ) dut (
      .sm_clk              (sm_clk),
      .reset               (reset),
      .start_request       (start_request),
      .reset_start_request (reset_start_request),
      .finish              (finish),
      .input_arguments     (input_arguments),
      .received_data       (received_data),
      .target_arguments    (target_arguments),
      .start_target        (start_target),
      .target_finished     (target_finished),
      .target_data         (target_data),
      .grant_id            (grant_id),
      .busy                (busy),
      .timeout_err         (timeout_err)
   );

   initial sm_clk = 1'b0;
   always #5 sm_clk = ~sm_clk;

   // Round-robin rule: first pending requester after the last one served.
   function automatic int rr_pick(input logic [3:0] r, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (r[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [31:0] model_data();
      return {exp_slot[3], exp_slot[2], exp_slot[1], exp_slot[0]};
   endfunction

   task automatic apply_reset();
      reset           = 1'b0;
      start_request   = '0;
      target_finished = 1'b0;
      target_data     = '0;
      repeat (2) @(posedge sm_clk);
      @(negedge sm_clk);
      reset = 1'b1;
      @(posedge sm_clk);
      #1;
      last_grant = 3;
      for (int i = 0; i < 4; i++) exp_slot[i] = '0;
   endtask

   // One transaction from an IDLE cycle back to the next IDLE cycle.
   task automatic run_txn(input int wcyc, input logic [7:0] data,
                          input logic [3:0] raise, input bit glitch,
                          output int got_id, output longint t_start);
      int exp_id;
      exp_id  = rr_pick(start_request, last_grant);
      got_id  = -1;
      t_start = 0;
      n_cmp++;
      if (exp_id < 0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_entry: busy %b req %b", busy, start_request);
         return;
      end
      @(posedge sm_clk);
      #1;
      t_start = $time;
      got_id  = int'(grant_id);
      n_cmp++;
      if (start_target !== 1'b1) begin
         n_bad++;
         $display("FAIL start_pulse: got %b want 1", start_target);
      end
      n_cmp++;
      if (reset_start_request !== 4'(1 << exp_id)) begin
         n_bad++;
         $display("FAIL ack_pulse: got %b want %b", reset_start_request, 4'(1 << exp_id));
      end
      n_cmp++;
      if (grant_id !== 2'(exp_id)) begin
         n_bad++;
         $display("FAIL grant_start: got %0d want %0d", grant_id, exp_id);
      end
      n_cmp++;
      if (target_arguments !== input_arguments[exp_id*32 +: 32]) begin
         n_bad++;
         $display("FAIL target_args: got %h want %h", target_arguments, input_arguments[exp_id*32 +: 32]);
      end
      start_request[exp_id] = 1'b0;
      if (glitch) target_finished = 1'b1;
      @(posedge sm_clk);
      #1;
      target_finished = 1'b0;
      start_request   = start_request | raise;
      repeat (wcyc) begin
         n_cmp++;
         if (start_target !== 1'b0 || finish !== 4'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_state: start %b finish %b busy %b want 0 0000 1", start_target, finish, busy);
         end
         n_cmp++;
         if (target_arguments !== input_arguments[exp_id*32 +: 32]) begin
            n_bad++;
            $display("FAIL wait_args: got %h want %h", target_arguments, input_arguments[exp_id*32 +: 32]);
         end
         @(posedge sm_clk);
         #1;
      end
      target_finished = 1'b1;
      target_data     = data;
      @(posedge sm_clk);
      #1;
      target_finished = 1'b0;
      n_cmp++;
      if (finish !== 4'b0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL capture_state: finish %b busy %b want 0000 1", finish, busy);
      end
      @(posedge sm_clk);
      #1;
      target_data      = 8'($urandom);
      exp_slot[exp_id] = data;
      last_grant       = exp_id;
      n_cmp++;
      if (finish !== 4'(1 << exp_id)) begin
         n_bad++;
         $display("FAIL finish_pulse: got %b want %b", finish, 4'(1 << exp_id));
      end
      n_cmp++;
      if (received_data !== model_data()) begin
         n_bad++;
         $display("FAIL result_slots: got %h want %h", received_data, model_data());
      end
      n_cmp++;
      if (timeout_err !== 1'b0 || reset_start_request !== 4'b0) begin
         n_bad++;
         $display("FAIL finish_side: tmo %b ack %b want 0 0000", timeout_err, reset_start_request);
      end
      @(posedge sm_clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || finish !== 4'b0) begin
         n_bad++;
         $display("FAIL back_idle: busy %b finish %b want 0 0000", busy, finish);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if (busy !== 1'b0 || grant_id !== 2'd0 || received_data !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_regs: busy %b grant %0d data %h want 0 0 0", busy, grant_id, received_data);
      end
      n_cmp++;
      if (start_target !== 1'b0 || reset_start_request !== 4'b0 || finish !== 4'b0 || timeout_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_pulses: st %b ack %b fin %b tmo %b want all 0", start_target, reset_start_request, finish, timeout_err);
      end
      target_finished = 1'b1;
      repeat (3) begin
         @(posedge sm_clk);
         #1;
         n_cmp++;
         if (start_target !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_hold: start %b busy %b want 0 0", start_target, busy);
         end
      end
      target_finished = 1'b0;
   endtask

   task automatic test_single();
      int     id;
      longint t;
      input_arguments[64 +: 32] = 32'hDEADBEEF;
      start_request = 4'b0100;
      run_txn(3, 8'h5A, 4'b0000, 1'b0, id, t);
      n_cmp++;
      if (received_data[23:16] !== 8'h5A || id !== 2) begin
         n_bad++;
         $display("FAIL single: slot2 %h id %0d want 5a 2", received_data[23:16], id);
      end
   endtask

   task automatic test_all_four();
      int     id;
      longint t;
      apply_reset();
      for (int i = 0; i < 4; i++) input_arguments[i*32 +: 32] = $urandom;
      start_request = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         run_txn(i, 8'(8'h21 * (i + 1)), 4'b0000, 1'b0, id, t);
         n_cmp++;
         if (id !== i) begin
            n_bad++;
            $display("FAIL all_four_order: got %0d want %0d", id, i);
         end
      end
   endtask

   task automatic test_rerequest();
      int     id;
      longint t;
      int     want [3];
      want = '{1, 3, 1};
      start_request = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         run_txn(1, 8'($urandom), (i == 0) ? 4'b0010 : 4'b0000, 1'b0, id, t);
         n_cmp++;
         if (id !== want[i]) begin
            n_bad++;
            $display("FAIL rerequest_order: step %0d got %0d want %0d", i, id, want[i]);
         end
      end
   endtask

   task automatic test_finish_in_start();
      int     id;
      longint t;
      start_request = 4'b0001;
      run_txn(2, 8'hC3, 4'b0000, 1'b1, id, t);
   endtask

   task automatic test_back_to_back();
      int     id0;
      int     id1;
      longint t0;
      longint t1;
      start_request = 4'b1100;
      run_txn(0, 8'h11, 4'b0000, 1'b0, id0, t0);
      run_txn(0, 8'h22, 4'b0000, 1'b0, id1, t1);
      n_cmp++;
      if (t1 - t0 != 50) begin
         n_bad++;
         $display("FAIL turnaround: got %0d ns want 50 ns", t1 - t0);
      end
   endtask

   task automatic test_reset_mid();
      int     id;
      longint t;
      start_request = 4'b0010;
      @(posedge sm_clk);
      #1;
      start_request = 4'b0000;
      @(posedge sm_clk);
      #1;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || received_data !== 32'h0 || grant_id !== 2'd0) begin
         n_bad++;
         $display("FAIL async_reset: busy %b data %h grant %0d want 0 0 0", busy, received_data, grant_id);
      end
      @(posedge sm_clk);
      #1;
      n_cmp++;
      if (finish !== 4'b0 || start_target !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_no_finish: finish %b start %b want 0000 0", finish, start_target);
      end
      @(negedge sm_clk);
      reset = 1'b1;
      @(posedge sm_clk);
      #1;
      last_grant = 3;
      for (int i = 0; i < 4; i++) exp_slot[i] = '0;
      start_request = 4'b1001;
      run_txn(1, 8'h77, 4'b0000, 1'b0, id, t);
      n_cmp++;
      if (id !== 0) begin
         n_bad++;
         $display("FAIL post_reset_grant: got %0d want 0", id);
      end
      start_request = 4'b0000;
   endtask

   task automatic test_random();
      int         id;
      longint     t;
      logic [3:0] nreq;
      for (int it = 0; it < 60; it++) begin
         nreq = 4'($urandom_range(0, 15)) & ~start_request;
         for (int i = 0; i < 4; i++) begin
            if (nreq[i]) input_arguments[i*32 +: 32] = $urandom;
         end
         start_request = start_request | nreq;
         if (start_request == 4'b0) begin
            target_finished = 1'b1;
            @(posedge sm_clk);
            #1;
            target_finished = 1'b0;
            n_cmp++;
            if (start_target !== 1'b0 || busy !== 1'b0) begin
               n_bad++;
               $display("FAIL random_idle: start %b busy %b want 0 0", start_target, busy);
            end
         end else begin
            run_txn($urandom_range(0, 4), 8'($urandom), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0), id, t);
         end
      end
      start_request = 4'b0000;
   endtask

`ifdef SHARED_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int exp_id;
      int cyc;
      @(posedge sm_clk);
      #1;
      start_request = 4'b0100;
      exp_id = rr_pick(start_request, last_grant);
      @(posedge sm_clk);
      #1;
      start_request = 4'b0000;
      @(posedge sm_clk);
      #1;
      cyc = 0;
      while (finish === 4'b0 && cyc < 20) begin
         @(posedge sm_clk);
         #1;
         cyc++;
      end
      n_cmp++;
      if (finish !== 4'(1 << exp_id) || timeout_err !== 1'b1 || cyc != TOC) begin
         n_bad++;
         $display("FAIL timeout: finish %b tmo %b cycles %0d want %b 1 %0d", finish, timeout_err, cyc, 4'(1 << exp_id), TOC);
      end
      n_cmp++;
      if (received_data !== model_data()) begin
         n_bad++;
         $display("FAIL timeout_slot: got %h want %h", received_data, model_data());
      end
      last_grant = exp_id;
      @(posedge sm_clk);
      #1;
   endtask
`endif

   initial begin
      n_cmp           = 0;
      n_bad           = 0;
      reset           = 1'b0;
      start_request   = '0;
      input_arguments = '0;
      target_finished = 1'b0;
      target_data     = '0;
      test_reset();
      test_single();
      test_all_four();
      test_rerequest();
      test_finish_in_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef SHARED_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
